// File: rtl/ask_demod.sv
// ask_demod: non-coherent ASK demodulator. Integrates |in - MID| over one symbol and thresholds the sum.
// Optional sticky out-of-range flag is built only when ASK_DEMOD_RANGE_CHECK_EN is defined.
module ask_demod #(
  parameter int unsigned MID             = 10000,
  parameter int unsigned SAMPLES_PER_SYM = 64,
  parameter int unsigned THRESHOLD       = 203540
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        in_valid,
  output logic        dout,
  output logic        dout_valid,
  output logic        range_err
);

  localparam logic [15:0] MID_V   = 16'(MID);
  localparam logic [19:0] THR_V   = 20'(THRESHOLD);
  localparam logic [5:0]  LAST_PH = 6'(SAMPLES_PER_SYM - 1);

  typedef enum logic {ACCUM, DECIDE} state_e;

  function automatic logic [15:0] abs_dev(input logic [15:0] x);
    logic signed [16:0] diff;
    diff = $signed({1'b0, x}) - $signed({1'b0, MID_V});
    return (diff < 0) ? 16'(-diff) : diff[15:0];
  endfunction

  state_e      state;
  logic [5:0]  phase_q, phase_d;
  logic [19:0] acc_q, acc_d;
  logic        dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic [15:0] dev;
  logic [19:0] total;

  assign dev   = abs_dev(in);
  assign total = acc_q + {4'b0, dev};
  assign state = (phase_q == LAST_PH) ? DECIDE : ACCUM;

  // Next-state: the symbol-end sample clears the integrator so the following sample starts fresh
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    if (in_valid) begin
      unique case (state)
        ACCUM: begin
          phase_d = phase_q + 6'd1;
          acc_d   = total;
        end
        DECIDE: begin
          phase_d = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (in_valid && (state == DECIDE)) begin
      dout_d       = (total > THR_V);
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= '0;
      acc_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef ASK_DEMOD_RANGE_CHECK_EN
  localparam logic [16:0] RANGE_MAX = 17'(2 * MID);

  logic range_err_q, range_err_d;

  // Sticky until reset; offending samples are still integrated
  always_comb begin
    range_err_d = range_err_q | (in_valid && ({1'b0, in} > RANGE_MAX));
  end

  always_ff @(posedge clk) begin
    if (rst) range_err_q <= 1'b0;
    else     range_err_q <= range_err_d;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ask_demod.sv
// tb_ask_demod: randomized and directed stimulus against a queue-based symbol model of ask_demod.
module tb_ask_demod;

`ifdef ASK_DEMOD_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_s = 1'b1;
  logic [15:0] in_s = 16'd0;
  logic        in_valid_s = 1'b0;
  logic        dout, dout_valid, range_err;

  int total = 0;
  int bad   = 0;

  ask_demod dut (
    .clk       (clk),
    .rst       (rst_s),
    .in        (in_s),
    .in_valid  (in_valid_s),
    .dout      (dout),
    .dout_valid(dout_valid),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  // Quarter-wave of round(1000*sin(2*pi*k/64)), k=0..16
  int qtab[17] = '{0, 98, 195, 290, 383, 471, 556, 634, 707, 773, 831, 882, 924, 957, 981, 995, 1000};

  function automatic int mark_s(input int k);
    int m, a;
    m = k % 32;
    a = (m <= 16) ? qtab[m] : qtab[32 - m];
    return (k < 32) ? 10000 + 10 * a : 10000 - 10 * a;
  endfunction

  // Model: collect valid samples of the current symbol; decide on the 64th
  int     symq[$];
  bit     exp_dv = 1'b0, exp_dout = 1'b0, exp_rerr = 1'b0;
  bit     chk_en = 1'b0;
  longint last_sum = -1;

  always @(posedge clk) begin
    if (rst_s) begin
      symq.delete();
      exp_dv   = 1'b0;
      exp_dout = 1'b0;
      exp_rerr = 1'b0;
      chk_en   = 1'b1;
    end else begin
      exp_dv = 1'b0;
      if (in_valid_s) begin
        int s;
        s = int'(in_s);
        symq.push_back((s >= 10000) ? s - 10000 : 10000 - s);
        if (RC_EN && s > 20000) exp_rerr = 1'b1;
        if (symq.size() == 64) begin
          longint sum;
          sum = 0;
          foreach (symq[i]) sum += symq[i];
          sum      = sum % (64'd1 << 20);
          last_sum = sum;
          exp_dout = (sum > 203540);
          exp_dv   = 1'b1;
          symq.delete();
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout_valid", dout_valid, exp_dv);
      check("dout", dout, exp_dout);
      check("range_err", range_err, exp_rerr);
    end
  end

  task automatic drive(input int v, input bit vld, input bit r);
    in_s       = 16'(v);
    in_valid_s = vld;
    rst_s      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_const(input int v, input int n);
    for (int i = 0; i < n; i++) drive(v, 1'b1, 1'b0);
  endtask

  initial begin
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_rerr", range_err, 0);
    drive(0, 1'b0, 1'b0);

    // Idle symbol
    send_const(10000, 63);
    check("idle_no_early_dv", dout_valid, 0);
    send_const(10000, 1);
    check("idle_dv", dout_valid, 1);
    check("idle_dout", dout, 0);
    check("idle_sum", last_sum, 0);

    // Mark symbol then idle symbol, back to back
    for (int k = 0; k < 64; k++) drive(mark_s(k), 1'b1, 1'b0);
    check("mark_dv", dout_valid, 1);
    check("mark_dout", dout, 1);
    check("mark_sum", last_sum, 407080);
    send_const(10000, 63);
    check("b2b_hold_dout", dout, 1);
    send_const(10000, 1);
    check("b2b_dv", dout_valid, 1);
    check("b2b_dout", dout, 0);

    // Threshold edges
    send_const(13180, 64);
    check("thr_lo_sum", last_sum, 203520);
    check("thr_lo_dout", dout, 0);
    send_const(13181, 64);
    check("thr_hi_sum", last_sum, 203584);
    check("thr_hi_dout", dout, 1);
    send_const(10000, 64);

    // Gapped mark symbol
    for (int k = 0; k < 64; k++) begin
      drive(mark_s(k), 1'b1, 1'b0);
      if (k != 63 && (k % 5) == 4)
        for (int g = 0; g < 3; g++) drive(12345, 1'b0, 1'b0);
    end
    check("gap_dv", dout_valid, 1);
    check("gap_dout", dout, 1);
    check("gap_sum", last_sum, 407080);

    // Reset mid-symbol; sample presented with reset is dropped
    for (int k = 0; k < 30; k++) drive(mark_s(k), 1'b1, 1'b0);
    drive(20000, 1'b1, 1'b1);
    check("midrst_dout", dout, 0);
    send_const(10000, 63);
    check("midrst_no_dv", dout_valid, 0);
    send_const(10000, 1);
    check("midrst_dv", dout_valid, 1);
    check("midrst_dout2", dout, 0);

    // Range check inside an idle symbol
    send_const(10000, 10);
    send_const(20000, 1);
    check("range_at_limit", range_err, 0);
    send_const(20001, 1);
    check("range_over", range_err, RC_EN);
    send_const(10000, 52);
    check("range_sticky", range_err, RC_EN);
    check("range_sym_dv", dout_valid, 1);
    drive(0, 1'b0, 1'b1);
    check("range_cleared", range_err, 0);

    // Randomized traffic with occasional resets and out-of-range samples
    for (int c = 0; c < 20000; c++) begin
      int v;
      int mode;
      mode = int'($urandom_range(0, 9));
      if (mode < 4)      v = 10000 + int'($urandom_range(0, 8000)) - 4000;
      else if (mode < 8) v = int'($urandom_range(0, 20000));
      else if (mode < 9) v = int'($urandom_range(13100, 13260));
      else               v = int'($urandom_range(0, 65535));
      drive(v, $urandom_range(0, 9) < 7, $urandom_range(0, 1499) == 0);
    end

    drive(0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ask_demod.md
# ask_demod

Non-coherent ASK demodulator: the receive-side counterpart of the team's ASK modulator. It takes the modulator's 16-bit sampled output stream, removes the DC midpoint, and integrates the absolute deviation over one 64-sample carrier period. It then compares the sum against a threshold and emits one recovered data bit per symbol with a one-cycle valid strobe. It sits between the sample source (modulator output or channel model) and the bit sink/checker.

## Interface
- MID, 10000: DC midpoint of the modulated signal; this is the idle (Din=0) level.
- SAMPLES_PER_SYM, 64: valid samples per symbol (one carrier period); must be a power of two, ≤ 64.
- THRESHOLD, 203540: decision threshold on the integrated deviation; equals half the full-amplitude (10× sine) sum of 407080.
- clk  in  1  clock; everything samples on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- in  in  16  unsigned sample, nominal range 0..20000.
- in_valid  in  1  `in` is a valid sample this cycle.
- dout  out  1  recovered bit; holds until the next decision.
- dout_valid  out  1  one-cycle pulse when `dout` is updated.
- range_err  out  1  sticky out-of-range flag (see Configuration).

## Operation
- Deviation (combinational): dev = (in ≥ MID) ? in − MID : MID − in, 16-bit unsigned.
- Phase counter `phase` (6 bits):
  - Increments on each `in_valid` sample.
  - Wraps from SAMPLES_PER_SYM−1 to 0.
  - Holds when `in_valid`=0.
- Accumulator `acc` (20 bits, unsigned). Maximum in-range sum is 64×10000 = 640000 < 2^20, so no overflow for in-range input. Out-of-range input wraps modulo 2^20 with no saturation.
- On a valid sample with phase < SAMPLES_PER_SYM−1: acc ← acc + dev.
- On a valid sample with phase = SAMPLES_PER_SYM−1 (symbol end):
  - total = acc + dev.
  - dout ← (total > THRESHOLD) (strictly greater).
  - dout_valid ← 1.
  - acc ← 0.
  - phase ← 0.
- States: ACCUM (phase 0..SAMPLES_PER_SYM−2) and DECIDE (the symbol-end sample). DECIDE returns to ACCUM in the same cycle. There is no idle state; integration proceeds whenever `in_valid` is high.
- Symbol alignment is fixed by reset: the first valid sample after `rst` deasserts is phase 0. No timing recovery is performed.
- `in_valid` gaps of any length only stall `phase` and `acc`. The result is identical to the gap-free stream.

## Timing
- Reset, synchronous, 1 cycle with `rst`=1:
  - phase=0, acc=0.
  - dout=0, dout_valid=0, range_err=0.
- Reset mid-symbol discards the partial sum. No dout_valid is produced for the aborted symbol.
- Latency: dout/dout_valid are registered. They appear the cycle after the clock edge that samples the last valid sample of a symbol.
- dout_valid is high for exactly one cycle per symbol.
- Back-to-back symbols produce strobes SAMPLES_PER_SYM cycles apart when `in_valid` is continuously high.
- The sample arriving the cycle after DECIDE starts the next symbol at phase 0 with acc=0. No samples are lost.
- `rst` and `in_valid` high in the same cycle: reset wins and the sample is dropped.

## Configuration
- ASK_DEMOD_RANGE_CHECK_EN defined:
  - range_err is set on any valid sample with in > 2×MID.
  - It stays set until `rst`.
  - The sample is still accumulated (wrapping rules above).
- ASK_DEMOD_RANGE_CHECK_EN undefined: range_err is tied to 0 and no compare logic is built.

## Test plan
- Idle symbol: reset, then 64 valid samples of 10000. Expect acc sum 0, dout=0, and dout_valid pulsed once, 1 cycle after the 64th sample.
- Mark symbol: 64 samples of 10×(1000·sin(2πk/64)+1000), k=0..63. Expect sum 407080 and dout=1. Follow with an idle symbol and expect dout=0 with a strobe exactly 64 cycles later.
- Threshold edge, sum 203520: 64 samples of 13180. Expect dout=0.
- Threshold edge, sum 203584: 64 samples of 13181. Expect dout=1.
- Gapped input: the mark symbol with `in_valid` low for 3 cycles after every 5th sample. Expect dout=1, and the strobe 1 cycle after the 64th valid sample.
- Reset mid-symbol: 30 mark samples, `rst` for 1 cycle, then 64 idle samples. Expect no strobe for the aborted symbol, then dout=0.
- Range check with macro defined: one sample of 20001 inside an idle symbol. Expect range_err=1 from the next cycle until `rst`. With the macro undefined, expect range_err=0 throughout.
